// File: rtl/counter_pkg.sv
// Shared types, default widths and sequence helper for the counter checker.
package counter_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam int ERR_W_DEF  = 8;
  localparam int STEP_W_DEF = 16;

  // Successor of prev in an n-bit wrapping count sequence.
  function automatic logic [31:0] next_val(input logic [31:0] prev, input int unsigned n);
    logic [31:0] mask;
    mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
    return (prev + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/checker_sat_cnt.sv
// Saturating event counter: counts inc pulses, sticks at all ones.
// Latency: count reflects inc one clock later. No backpressure.
// Synchronous active-high reset clears the count.
module checker_sat_cnt
  import counter_pkg::*;
#(
  parameter int WIDTH = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Checks a monitored count bus for +1 steps, each value held W clocks; COUNTER_CHECKER_TIMING_EN enables hold checks.
// Latency: all outputs registered, one clock after the cnt_in sample causing the event.
// Backpressure: none; pure observer, samples cnt_in every clock.
module counter_checker
  import counter_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 10,
  parameter int ERR_W  = ERR_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N-1:0]      cnt_in,
  output logic              locked,
  output logic              err_pulse,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [STEP_W-1:0] step_count
);

  if (W < 1) begin : g_w_check
    $error("counter_checker: W must be >= 1");
  end

  state_t       state;
  logic [N-1:0] prev;
  logic         chg;
  logic         seq_ok;
  logic         track;
  logic         stall;
  logic         time_ok;
  logic         good;
  logic         err;

  assign chg    = (cnt_in != prev);
  assign seq_ok = (cnt_in == N'(next_val(32'(prev), N)));
  assign track  = enable && (state == LOCKED);

`ifdef COUNTER_CHECKER_TIMING_EN
  localparam int HW = (W > 1) ? $clog2(W) : 1;
  logic [HW-1:0] hold;

  // hold counts repeat cycles of the current value; it never needs to exceed W-1.
  assign time_ok = (hold == HW'(W - 1));
  assign stall   = !chg && time_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
    end else if (!track || chg || stall) begin
      hold <= '0;
    end else begin
      hold <= hold + HW'(1);
    end
  end
`else
  assign time_ok = 1'b1;
  assign stall   = 1'b0;
`endif

  assign good = track && chg && seq_ok && time_ok;
  assign err  = track && (stall || (chg && !good));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      prev       <= cnt_in;
      err_pulse  <= err;
      wrap_pulse <= good && (prev == '1);
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
          // The first observed change only establishes phase, so it never errors.
          ACQUIRE: begin
            if (chg) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (err) begin
              state  <= ACQUIRE;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  checker_sat_cnt #(.WIDTH(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err),
    .count (err_count)
  );

  checker_sat_cnt #(.WIDTH(STEP_W)) u_step_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (good),
    .count (step_count)
  );

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: vector table, directed corner sequences and random stimulus against a cycle model.
module tb_counter_checker;

  localparam int N      = 4;
  localparam int W      = 10;
  localparam int ERR_W  = 8;
  localparam int STEP_W = 16;
  localparam int MODV   = 1 << N;
  localparam int EMAX   = (1 << ERR_W) - 1;
  localparam int SMAX   = (1 << STEP_W) - 1;
`ifdef COUNTER_CHECKER_TIMING_EN
  localparam bit TIMING = 1'b1;
`else
  localparam bit TIMING = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [N-1:0]      cnt_in = '0;
  logic              locked;
  logic              err_pulse;
  logic              wrap_pulse;
  logic [ERR_W-1:0]  err_count;
  logic [STEP_W-1:0] step_count;

  counter_checker #(.N(N), .W(W), .ERR_W(ERR_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cnt_in     (cnt_in),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wrap_seen = 0;

  // Reference: mode 0 = disabled, 1 = hunting for phase, 2 = tracking.
  int m_mode, m_prev, m_run, m_ec, m_sc;
  bit m_locked, m_err, m_wrap;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int v);
    bit is_bad;
    if (r) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_ec = 0; m_sc = 0;
      m_locked = 0; m_err = 0; m_wrap = 0;
      return;
    end
    m_err = 0; m_wrap = 0; is_bad = 0;
    if (!e) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (v != m_prev) begin m_mode = 2; m_run = 0; end
    end else begin
      if (v == m_prev) begin
        m_run++;
        if (TIMING && m_run == W) is_bad = 1;
      end else if (v == (m_prev + 1) % MODV && (!TIMING || m_run == W - 1)) begin
        if (m_sc < SMAX) m_sc++;
        if (m_prev == MODV - 1) m_wrap = 1;
        m_run = 0;
      end else is_bad = 1;
      if (is_bad) begin
        m_err = 1;
        if (m_ec < EMAX) m_ec++;
        m_mode = 1;
      end
    end
    m_prev = v;
    m_locked = (m_mode == 2);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(reset, enable, int'(cnt_in));
    #2;
    if (wrap_pulse) wrap_seen++;
    chk("model locked", locked, m_locked);
    chk("model err_pulse", err_pulse, m_err);
    chk("model wrap_pulse", wrap_pulse, m_wrap);
    chk("model err_count", err_count, m_ec);
    chk("model step_count", step_count, m_sc);
  endtask

  task automatic drive(input bit r, input bit e, input int v, input int len);
    reset = r; enable = e; cnt_in = N'(v);
    repeat (len) cyc();
  endtask

  typedef struct {
    bit en;
    int val;
    int len;
    bit exp_err1;
    bit exp_lock;
    int exp_ec;
    int exp_sc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cur, rnd, c, len, v;
    bit rr, e;
    int ec0, sc0;

    vecs[0]  = '{1, 0, 10, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 10, 0, 1, 0, 0};
    vecs[2]  = '{1, 2, 10, 0, 1, 0, 1};
    vecs[3]  = '{1, 4, 10, 1, 0, 1, 1};
    vecs[4]  = '{1, 5, 10, 0, 1, 1, 1};
    vecs[5]  = '{1, 6, 10, 0, 1, 1, 2};
    vecs[6]  = '{0, 7, 3,  0, 0, 1, 2};
    vecs[7]  = '{1, 7, 10, 0, 0, 1, 2};
    vecs[8]  = '{1, 8, 10, 0, 1, 1, 2};
    vecs[9]  = '{1, 9, 10, 0, 1, 1, 3};
    vecs[10] = '{1, 11, 10, 1, 0, 2, 3};
    vecs[11] = '{1, 12, 10, 0, 1, 2, 3};
    vecs[12] = '{1, 13, 10, 0, 1, 2, 4};

    // Reset state
    drive(1, 1, 0, 5);
    chk("reset locked", locked, 0);
    chk("reset err_count", err_count, 0);
    chk("reset step_count", step_count, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].en, vecs[i].val, 1);
      chk($sformatf("vec%0d err_pulse", i), err_pulse, vecs[i].exp_err1);
      drive(0, vecs[i].en, vecs[i].val, vecs[i].len - 1);
      chk($sformatf("vec%0d locked", i), locked, vecs[i].exp_lock);
      chk($sformatf("vec%0d err_count", i), err_count, vecs[i].exp_ec);
      chk($sformatf("vec%0d step_count", i), step_count, vecs[i].exp_sc);
    end

    // Clean run with one wrap
    drive(1, 1, 0, 5);
    wrap_seen = 0;
    drive(0, 1, 0, 10);
    drive(0, 1, 1, 1);
    chk("first change locked", locked, 1);
    drive(0, 1, 1, 9);
    for (int i = 2; i <= 20; i++) drive(0, 1, i % MODV, 10);
    chk("run step_count", step_count, 19);
    chk("run err_count", err_count, 0);
    chk("run wraps", wrap_seen, 1);

    // Long hold of 7
    drive(0, 1, 5, 10);
    drive(0, 1, 6, 10);
    for (int k = 0; k < 15; k++) begin
      drive(0, 1, 7, 1);
      if (k == 10) chk("stall err_pulse", err_pulse, TIMING);
    end
    chk("stall err_count", err_count, TIMING ? 1 : 0);
    chk("stall step_count", step_count, 22);

    // Early step: 9 held only 6 clocks
    drive(0, 1, 8, 10);
    drive(0, 1, 9, 6);
    drive(0, 1, 10, 10);
    chk("early err_count", err_count, TIMING ? 2 : 0);
    chk("early step_count", step_count, TIMING ? 23 : 25);
    chk("early locked", locked, TIMING ? 0 : 1);

    // Mid-sequence reset, then a skip 3->5
    drive(0, 1, 11, 10);
    drive(0, 1, 12, 10);
    chk("pre-reset locked", locked, 1);
    drive(1, 1, 13, 1);
    chk("mid reset locked", locked, 0);
    chk("mid reset err_pulse", err_pulse, 0);
    chk("mid reset wrap_pulse", wrap_pulse, 0);
    chk("mid reset err_count", err_count, 0);
    chk("mid reset step_count", step_count, 0);
    drive(0, 1, 13, 10);
    drive(0, 1, 1, 10);
    drive(0, 1, 2, 10);
    drive(0, 1, 3, 10);
    chk("relock err_count", err_count, 0);
    drive(0, 1, 5, 1);
    chk("skip err_pulse", err_pulse, 1);
    chk("skip locked", locked, 0);
    drive(0, 1, 5, 9);
    drive(0, 1, 6, 1);
    chk("skip relock", locked, 1);
    drive(0, 1, 6, 9);
    drive(0, 1, 7, 10);
    drive(0, 1, 8, 10);
    chk("skip err_count", err_count, 1);
    chk("skip step_count", step_count, 4);

    // Error counter saturation
    drive(1, 1, 0, 1);
    v = 0;
    for (int i = 0; i < 700; i++) begin
      v = (v + 2) % MODV;
      drive(0, 1, v, 1);
    end
    chk("sat err_count", err_count, EMAX);
    chk("sat step_count", step_count, 0);

    // Random segments
    drive(1, 1, 0, 1);
    cur = 0;
    for (int s = 0; s < 400; s++) begin
      rnd = $urandom_range(0, 99);
      rr = (rnd < 3);
      e = !(rnd >= 3 && rnd < 10);
      c = $urandom_range(0, 9);
      if (c < 7) cur = (cur + 1) % MODV;
      else if (c > 7) cur = $urandom_range(0, MODV - 1);
      len = $urandom_range(0, 1) ? W : $urandom_range(1, 12);
      if (rr) len = 1;
      drive(rr, e, cur, len);
    end
    ec0 = m_ec; sc0 = m_sc;
    chk("random final err_count", err_count, ec0);
    chk("random final step_count", step_count, sc0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
